// File: rtl/aes_key_expand_seq_pkg.sv
// Shared AES definitions for the key schedule: S-box, word-level helpers,
// round-constant seed and the expansion FSM state type.
package aes_key_expand_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } ks_state_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic int num_words(input int nr);
      return 4 * (nr + 1);
   endfunction

   function automatic logic [7:0] sub_bytes(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sub_bytes(w[31:24]), sub_bytes(w[23:16]), sub_bytes(w[15:8]), sub_bytes(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on a 32-bit word; purely combinational so it
// can also serve an inverse-cipher key schedule.
module aes_sub_word
   import aes_key_expand_seq_pkg::*;
(
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   assign word_out = sub_word(word_in);

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key expansion: one schedule word per clock into a register
// array that is held as k_sch once ready is set.
module aes_key_expand_seq
   import aes_key_expand_seq_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_load,
   input  logic [32*Nk-1:0]  key,
   output logic [127:0]      k_sch [0:Nr],
   output logic              busy,
   output logic              ready,
   output ks_state_e         state_dbg
);

   localparam int W = num_words(Nr);

   // key_load is a fire-and-forget pulse with no back-pressure: it is honoured
   // in every state. ready is a level that stays high until the next key_load.
   ks_state_e   state_q, state_d;
   logic [5:0]  i_q;
   logic [2:0]  phase_q;
   logic [7:0]  rcon_q;
   logic        busy_q, ready_q;
   logic        load_word;
   logic [31:0] w_q   [W];
   logic [31:0] win_q [Nk];
   logic [31:0] prev_word, rot_in, sub_out, temp, new_word;

   always_comb begin
      state_d   = state_q;
      load_word = 1'b0;
      if (key_load) begin
         state_d = EXPAND;
      end else if (state_q == EXPAND) begin
         load_word = 1'b1;
         if (i_q == 6'(W - 1)) state_d = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         i_q     <= '0;
         phase_q <= '0;
         rcon_q  <= RCON_INIT;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == EXPAND);
         ready_q <= (state_d == DONE);
         if (key_load) begin
            i_q     <= 6'(Nk);
            phase_q <= '0;
            rcon_q  <= RCON_INIT;
         end else if (load_word) begin
            i_q     <= i_q + 6'd1;
            phase_q <= (phase_q == 3'(Nk - 1)) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
         end
      end
   end

   // phase_q tracks i mod Nk so no divider is needed for the Nk=6 case.
   assign prev_word = win_q[Nk-1];
   assign rot_in    = (phase_q == 3'd0) ? rot_word(prev_word) : prev_word;

   aes_sub_word u_sub_word (
      .word_in  (rot_in),
      .word_out (sub_out)
   );

   always_comb begin
      temp = prev_word;
      if (phase_q == 3'd0)                temp = sub_out ^ {rcon_q, 24'h0};
      else if (Nk == 8 && phase_q == 3'd4) temp = sub_out;
   end

   assign new_word = win_q[0] ^ temp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < W; j++)  w_q[j]   <= '0;
         for (int j = 0; j < Nk; j++) win_q[j] <= '0;
      end else if (key_load) begin
         for (int j = 0; j < Nk; j++) begin
            w_q[j]   <= key[32*(Nk-1-j) +: 32];
            win_q[j] <= key[32*(Nk-1-j) +: 32];
         end
      end else if (load_word) begin
         for (int j = Nk; j < W; j++)
            if (i_q == 6'(j)) w_q[j] <= new_word;
         for (int j = 0; j < Nk - 1; j++) win_q[j] <= win_q[j+1];
         win_q[Nk-1] <= new_word;
      end
   end

   always_comb begin
      for (int r = 0; r <= Nr; r++)
         k_sch[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
   end

   assign busy      = busy_q;
   assign ready     = ready_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq at Nk=4/6/8 against a FIPS-197 style model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;
   import aes_key_expand_seq_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ld4 = 1'b0, ld6 = 1'b0, ld8 = 1'b0;
   logic [127:0]  key4 = '0;
   logic [191:0]  key6 = '0;
   logic [255:0]  key8 = '0;
   logic [127:0]  ks4 [0:10];
   logic [127:0]  ks6 [0:12];
   logic [127:0]  ks8 [0:14];
   logic          busy4, busy6, busy8, rdy4, rdy6, rdy8;
   ks_state_e     st4, st6, st8;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    sbox_m [256];
   logic [31:0]   ref_w  [60];

   always #5 clk = ~clk;

   aes_key_expand_seq #(.Nk(4)) u4 (.clk(clk), .rst_n(rst_n), .key_load(ld4), .key(key4),
      .k_sch(ks4), .busy(busy4), .ready(rdy4), .state_dbg(st4));
   aes_key_expand_seq #(.Nk(6)) u6 (.clk(clk), .rst_n(rst_n), .key_load(ld6), .key(key6),
      .k_sch(ks6), .busy(busy6), .ready(rdy6), .state_dbg(st6));
   aes_key_expand_seq #(.Nk(8)) u8 (.clk(clk), .rst_n(rst_n), .key_load(ld8), .key(key8),
      .k_sch(ks8), .busy(busy8), .ready(rdy8), .state_dbg(st8));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] m_sub(input logic [31:0] x);
      return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
   endfunction

   // key is left-aligned: w[0] always sits in bits [255:224].
   task automatic ref_expand(input int nk, input logic [255:0] k);
      logic [7:0]  rc;
      logic [31:0] t;
      rc = 8'h01;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) begin
            ref_w[i] = k[255 - 32*i -: 32];
         end else begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
               t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gf_mul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
               t = m_sub(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
         end
      end
   endtask

   // ---------------- helpers ----------------
   function automatic logic [127:0] ks_of(input int sel, input int r);
      case (sel)
         4:       return ks4[r];
         6:       return ks6[r];
         default: return ks8[r];
      endcase
   endfunction

   function automatic logic rdy_of(input int sel);
      return (sel == 4) ? rdy4 : (sel == 6) ? rdy6 : rdy8;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel == 4) ? busy4 : (sel == 6) ? busy6 : busy8;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] r;
      for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
      return r;
   endfunction

   // Returns at the falling edge just after the load edge.
   task automatic load_key(input int sel, input logic [255:0] k);
      @(negedge clk);
      case (sel)
         4:       begin key4 = k[255 -: 128]; ld4 = 1'b1; end
         6:       begin key6 = k[255 -: 192]; ld6 = 1'b1; end
         default: begin key8 = k;             ld8 = 1'b1; end
      endcase
      @(negedge clk);
      ld4 = 1'b0; ld6 = 1'b0; ld8 = 1'b0;
   endtask

   task automatic wait_ready(input int sel, input int nk, input string tag);
      int cyc;
      cyc = 0;
      while (!rdy_of(sel) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 128'(cyc), 128'(4 * (nk + 7) - nk));
   endtask

   task automatic check_sched(input int sel, input int nk, input string tag);
      for (int r = 0; r <= nk + 6; r++)
         check($sformatf("%s_k%0d", tag, r), ks_of(sel, r),
               {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
   endtask

   task automatic run_key(input int sel, input int nk, input logic [255:0] k, input string tag);
      ref_expand(nk, k);
      load_key(sel, k);
      wait_ready(sel, nk, tag);
      check_sched(sel, nk, tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [255:0] ka, kb;
      int           bad;
      build_sbox();

      #2;
      check("rst_ready4", 128'(rdy4), 128'(0));
      check("rst_busy8",  128'(busy8), 128'(0));
      check("rst_k4_0",   ks4[0], '0);
      check("rst_k8_14",  ks8[14], '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready6", 128'(rdy6), 128'(0));

      ka = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      run_key(4, 4, ka, "fips128");
      check("fips128_k1",  ks4[1],  128'ha0fafe1788542cb123a339392a6c7605);
      check("fips128_k10", ks4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Reload while DONE: ready must drop on the load edge itself.
      ka = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      ref_expand(4, ka);
      load_key(4, ka);
      check("reload_ready_drop", 128'(rdy4), 128'(0));
      check("reload_busy",       128'(busy4), 128'(1));
      wait_ready(4, 4, "seq128");
      check_sched(4, 4, "seq128");
      check("seq128_k0",  ks4[0],  128'h000102030405060708090a0b0c0d0e0f);
      check("seq128_k10", ks4[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         key4 = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
         if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ks4[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) bad++;
      end
      check("hold_100_cycles", 128'(bad), 128'(0));

      run_key(6, 6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, "fips192");
      check("fips192_k12", ks6[12], 128'he98ba06f448c773c8ecc720401002202);

      run_key(8, 8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, "fips256");
      check("fips256_k14", ks8[14], 128'hfe4890d1e6188d0b046df344706c631e);

      // Abort: second load partway through the first expansion.
      ka = rand_key();
      kb = rand_key();
      load_key(4, ka);
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (rdy4 !== 1'b0 || busy4 !== 1'b1) bad++;
      end
      check("abort_busy_window", 128'(bad), 128'(0));
      run_key(4, 4, kb, "abort_b");

      // Asynchronous reset mid-expansion.
      load_key(8, rand_key());
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready8", 128'(rdy8), 128'(0));
      check("arst_busy8",  128'(busy8), 128'(0));
      bad = 0;
      for (int r = 0; r <= 14; r++) if (ks8[r] !== '0) bad++;
      for (int r = 0; r <= 10; r++) if (ks4[r] !== '0) bad++;
      check("arst_ksch_zero", 128'(bad), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_key(8, 8, rand_key(), "post_rst");

      for (int n = 0; n < 3; n++) begin
         run_key(4, 4, rand_key(), $sformatf("rnd4_%0d", n));
         run_key(6, 6, rand_key(), $sformatf("rnd6_%0d", n));
         run_key(8, 8, rand_key(), $sformatf("rnd8_%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
